win3x3_fetch_ctrl: RTL and testbench

- Read-side sequencer for the `input_mem` pixel store (9-bit row/col address, 8-bit data, synchronous read).
- On `start`, raster-scans the image and, for each output pixel, issues the nine 3x3 neighbourhood reads.
- Assembles the nine results into one window word and hands it to the downstream filter with a valid/ready handshake.
- Out-of-image taps are zero-padded.

---
 rtl/img_pkg.sv | 31 +++
 rtl/rd_tag_pipe.sv | 35 +++
 rtl/win3x3_fetch_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_win3x3_fetch_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared constants, tap-offset tables and types for the 3x3 window fetch path.
package img_pkg;

    localparam int unsigned DEF_AW       = 9;
    localparam int unsigned DEF_DW       = 8;
    localparam int unsigned DEF_IMG_ROWS = 200;
    localparam int unsigned DEF_IMG_COLS = 320;

    // Two's-complement offsets: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1; tap k = (dr+1)*3 + (dc+1)
    localparam logic [1:0] TAP_DR [0:8] = '{2'b11, 2'b11, 2'b11,
                                            2'b00, 2'b00, 2'b00,
                                            2'b01, 2'b01, 2'b01};
    localparam logic [1:0] TAP_DC [0:8] = '{2'b11, 2'b00, 2'b01,
                                            2'b11, 2'b00, 2'b01,
                                            2'b11, 2'b00, 2'b01};

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StPresent,
        StDone
    } state_e;

    typedef struct packed {
        logic [3:0] tap;
        logic       oob;
        logic       vld;
    } tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line that tags each issued read so its data lands in the right window slot.
module rd_tag_pipe
    import img_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  tag_t i_tag,
    output tag_t o_tag
);

    tag_t r_pipe [RD_LAT];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_pipe[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_tag = r_pipe[RD_LAT-1];

endmodule

// File: rtl/win3x3_fetch_ctrl.sv
// Raster-scans the image, issues nine neighbourhood reads per pixel and presents
// the zero-padded 3x3 window over a valid/ready handshake.
module win3x3_fetch_ctrl
    import img_pkg::*;
#(
    parameter int unsigned IMG_ROWS = DEF_IMG_ROWS,
    parameter int unsigned IMG_COLS = DEF_IMG_COLS,
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic [AW-1:0]     o_pxl_row,
    output logic [AW-1:0]     o_pxl_col,
    input  logic [DW-1:0]     i_mem_data,
    output logic              o_win_valid,
    input  logic              i_win_ready,
    output logic [9*DW-1:0]   o_win_data,
    output logic [AW-1:0]     o_win_row,
    output logic [AW-1:0]     o_win_col,
    output logic              o_busy,
    output logic              o_done
);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [3:0]      r_tap;
    logic [1:0]      r_drain;
    logic [AW-1:0]   r_row;
    logic [AW-1:0]   r_col;
    logic [AW-1:0]   r_pxl_row;
    logic [AW-1:0]   r_pxl_col;
    logic            r_oob;
    logic [9*DW-1:0] r_win;

    logic            w_start;
    logic            w_abort;
    logic            w_accept;
    logic            w_last_col;
    logic            w_last_win;
    logic [AW-1:0]   w_nxt_row;
    logic [AW-1:0]   w_nxt_col;
    logic            w_load_addr;
    logic [AW-1:0]   w_ac_row;
    logic [AW-1:0]   w_ac_col;
    logic [3:0]      w_ac_tap;
    logic [1:0]      w_dr;
    logic [1:0]      w_dc;
    logic [AW:0]     w_tap_row;
    logic [AW:0]     w_tap_col;
    logic            w_oob;
    tag_t            w_tag_in;
    tag_t            w_tag_out;

    assign w_start    = i_start && !i_abort;
    assign w_abort    = i_abort && (r_state != StIdle);
    assign w_accept   = (r_state == StPresent) && i_win_ready && !w_abort;
    assign w_last_col = (r_col == AW'(IMG_COLS - 1));
    assign w_last_win = w_last_col && (r_row == AW'(IMG_ROWS - 1));
    assign w_nxt_col  = w_last_col ? '0 : r_col + 1'b1;
    assign w_nxt_row  = w_last_win ? '0 : (w_last_col ? r_row + 1'b1 : r_row);

    // FSM: state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = StIdle;
        end else begin
            unique case (r_state)
                StIdle:    if (w_start) w_state_nxt = StFetch;
                StFetch:   if (r_tap == 4'd8) w_state_nxt = StDrain;
                StDrain:   if (r_drain == 2'(RD_LAT - 1)) w_state_nxt = StPresent;
                StPresent: if (i_win_ready) w_state_nxt = w_last_win ? StDone : StFetch;
                StDone:    w_state_nxt = StIdle;
                default:   w_state_nxt = StIdle;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        o_win_valid = (r_state == StPresent);
        o_busy      = (r_state != StIdle);
        o_done      = (r_state == StDone);
    end

    // The address register is loaded one cycle ahead so tap k's address is on the
    // bus during the cycle FETCH holds tap k.
    always_comb begin
        w_load_addr = 1'b0;
        w_ac_row    = r_row;
        w_ac_col    = r_col;
        w_ac_tap    = r_tap + 4'd1;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_load_addr = 1'b1;
                    w_ac_row    = '0;
                    w_ac_col    = '0;
                    w_ac_tap    = 4'd0;
                end
            end
            StFetch: w_load_addr = (r_tap != 4'd8);
            StPresent: begin
                if (i_win_ready && !w_last_win) begin
                    w_load_addr = 1'b1;
                    w_ac_row    = w_nxt_row;
                    w_ac_col    = w_nxt_col;
                    w_ac_tap    = 4'd0;
                end
            end
            default: w_load_addr = 1'b0;
        endcase
    end

    // One extra bit keeps -1 and >= limit distinct from any in-range coordinate
    assign w_dr      = TAP_DR[w_ac_tap];
    assign w_dc      = TAP_DC[w_ac_tap];
    assign w_tap_row = {1'b0, w_ac_row} + {{(AW-1){w_dr[1]}}, w_dr};
    assign w_tap_col = {1'b0, w_ac_col} + {{(AW-1){w_dc[1]}}, w_dc};
    assign w_oob     = w_tap_row[AW] || w_tap_col[AW] ||
                       (w_tap_row >= (AW+1)'(IMG_ROWS)) || (w_tap_col >= (AW+1)'(IMG_COLS));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pxl_row <= '0;
            r_pxl_col <= '0;
            r_oob     <= 1'b0;
        end else if (w_load_addr && !w_abort) begin
            r_pxl_row <= w_oob ? w_ac_row : w_tap_row[AW-1:0];
            r_pxl_col <= w_oob ? w_ac_col : w_tap_col[AW-1:0];
            r_oob     <= w_oob;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tap   <= '0;
            r_drain <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            if (r_state == StIdle && w_start) begin
                r_tap <= '0;
                r_row <= '0;
                r_col <= '0;
            end
            if (r_state == StFetch) begin
                r_tap <= (r_tap == 4'd8) ? 4'd0 : r_tap + 4'd1;
            end
            r_drain <= (r_state == StDrain) ? r_drain + 2'd1 : 2'd0;
            if (w_accept) begin
                r_row <= w_nxt_row;
                r_col <= w_nxt_col;
            end
        end
    end

    always_comb begin
        w_tag_in     = '0;
        w_tag_in.tap = r_tap;
        w_tag_in.oob = r_oob;
        w_tag_in.vld = (r_state == StFetch);
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_abort),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_win <= '0;
        end else if (w_abort) begin
            r_win <= '0;
        end else if (w_tag_out.vld) begin
            for (int k = 0; k < 9; k++) begin
                if (w_tag_out.tap == 4'(k)) begin
                    r_win[DW*k +: DW] <= w_tag_out.oob ? '0 : i_mem_data;
                end
            end
        end
    end

    assign o_pxl_row  = r_pxl_row;
    assign o_pxl_col  = r_pxl_col;
    assign o_win_data = r_win;
    assign o_win_row  = r_row;
    assign o_win_col  = r_col;

endmodule

// File: tb/tb_win3x3_fetch_ctrl.sv
// Directed bench: a 4x5 image at read latency 1 and a 1x1 image at read latency 3.
module tb_win3x3_fetch_ctrl;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic            a_start, a_abort, a_ready, a_valid, a_busy, a_done;
    logic [AW-1:0]   a_pxl_row, a_pxl_col, a_win_row, a_win_col;
    logic [DW-1:0]   a_mem_data;
    logic [9*DW-1:0] a_win_data;

    logic            b_start, b_abort, b_ready, b_valid, b_busy, b_done;
    logic [AW-1:0]   b_pxl_row, b_pxl_col, b_win_row, b_win_col;
    logic [DW-1:0]   b_mem_data, b_d1, b_d2, b_d3;
    logic [9*DW-1:0] b_win_data;

    win3x3_fetch_ctrl #(
        .IMG_ROWS (4), .IMG_COLS (5), .AW (AW), .DW (DW), .RD_LAT (1)
    ) u_dut_a (
        .i_clk (clk), .i_rst (rst), .i_start (a_start), .i_abort (a_abort),
        .o_pxl_row (a_pxl_row), .o_pxl_col (a_pxl_col), .i_mem_data (a_mem_data),
        .o_win_valid (a_valid), .i_win_ready (a_ready), .o_win_data (a_win_data),
        .o_win_row (a_win_row), .o_win_col (a_win_col), .o_busy (a_busy), .o_done (a_done)
    );

    win3x3_fetch_ctrl #(
        .IMG_ROWS (1), .IMG_COLS (1), .AW (AW), .DW (DW), .RD_LAT (3)
    ) u_dut_b (
        .i_clk (clk), .i_rst (rst), .i_start (b_start), .i_abort (b_abort),
        .o_pxl_row (b_pxl_row), .o_pxl_col (b_pxl_col), .i_mem_data (b_mem_data),
        .o_win_valid (b_valid), .i_win_ready (b_ready), .o_win_data (b_win_data),
        .o_win_row (b_win_row), .o_win_col (b_win_col), .o_busy (b_busy), .o_done (b_done)
    );

    // Pixel store models: pixel = row*16 + col (latency 1); single pixel 0xA5 (latency 3)
    always @(posedge clk) a_mem_data <= {a_pxl_row[3:0], a_pxl_col[3:0]};
    always @(posedge clk) begin
        b_d1 <= (b_pxl_row == '0 && b_pxl_col == '0) ? 8'hA5 : 8'hEE;
        b_d2 <= b_d1;
        b_d3 <= b_d2;
    end
    assign b_mem_data = b_d3;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [71:0] pack9(input logic [7:0] t0, input logic [7:0] t1,
                                          input logic [7:0] t2, input logic [7:0] t3,
                                          input logic [7:0] t4, input logic [7:0] t5,
                                          input logic [7:0] t6, input logic [7:0] t7,
                                          input logic [7:0] t8);
        return {t8, t7, t6, t5, t4, t3, t2, t1, t0};
    endfunction

    function automatic logic [71:0] model_win(input int row, input int col);
        logic [71:0] w;
        int r;
        int c;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            r = row + k / 3 - 1;
            c = col + k % 3 - 1;
            if (r >= 0 && r < 4 && c >= 0 && c < 5) w[8*k +: 8] = 8'(r * 16 + c);
        end
        return w;
    endfunction

    task automatic pulse_a_start();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    // Runs one 4x5 frame; stall_idx selects the window held with ready low for 7 cycles.
    task automatic run_frame(input int stall_idx);
        int n, nwin, ndone, stall, exp_r, exp_c, acc_n;
        logic seen, prev_acc;
        logic [90:0] cur, hold;
        nwin = 0; ndone = 0; stall = 0; exp_r = 0; exp_c = 0; acc_n = -10;
        seen = 1'b0; prev_acc = 1'b0; hold = '0;
        a_ready = 1'b1;
        pulse_a_start();
        n = 0;
        check_eq("busy_after_start", 96'(a_busy), 96'(1));
        while (ndone == 0 && n < 400) begin
            if (nwin == 0 && n == 2) check_eq("oob_addr_hold", {a_pxl_row, a_pxl_col}, 96'(0));
            if (nwin == 0 && n == 5) check_eq("tap5_addr", {a_pxl_row, a_pxl_col}, {9'd0, 9'd1});
            if (prev_acc) check_eq("valid_drop", 96'(a_valid), 96'(0));
            prev_acc = 1'b0;
            if (a_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    check_eq("first_valid_cyc", n, 10);
                end
                cur = {a_valid, a_win_row, a_win_col, a_win_data};
                if (nwin == stall_idx && stall < 7) begin
                    if (stall == 0) begin
                        hold = cur;
                        check_eq("stall_pos", {a_win_row, a_win_col}, {9'd1, 9'd3});
                    end else begin
                        check_eq("stall_stable", cur, hold);
                    end
                    a_ready = 1'b0;
                    stall++;
                end else begin
                    if (nwin == stall_idx) check_eq("stall_stable", cur, hold);
                    a_ready = 1'b1;
                    if (nwin == 1) check_eq("period", n - acc_n, 11);
                    check_eq("win_pos", {a_win_row, a_win_col}, {9'(exp_r), 9'(exp_c)});
                    check_eq("win_data", a_win_data, model_win(exp_r, exp_c));
                    if (exp_r == 0 && exp_c == 0)
                        check_eq("win_0_0", a_win_data, pack9(8'h00, 8'h00, 8'h00, 8'h00,
                                 8'h00, 8'h01, 8'h00, 8'h10, 8'h11));
                    if (exp_r == 2 && exp_c == 2)
                        check_eq("win_2_2", a_win_data, pack9(8'h11, 8'h12, 8'h13, 8'h21,
                                 8'h22, 8'h23, 8'h31, 8'h32, 8'h33));
                    if (exp_r == 3 && exp_c == 4)
                        check_eq("win_3_4", a_win_data, pack9(8'h23, 8'h24, 8'h00, 8'h33,
                                 8'h34, 8'h00, 8'h00, 8'h00, 8'h00));
                    nwin++;
                    acc_n = n;
                    prev_acc = 1'b1;
                    if (exp_c == 4) begin
                        exp_c = 0;
                        exp_r++;
                    end else begin
                        exp_c++;
                    end
                end
            end
            if (a_done) begin
                ndone++;
                check_eq("done_timing", n, acc_n + 1);
            end
            @(posedge clk); #1;
            n++;
        end
        check_eq("win_count", nwin, 20);
        check_eq("done_count", ndone, 1);
        check_eq("idle_after_done", {a_busy, a_done, a_valid}, 96'(0));
    endtask

    initial begin
        int nb, first, bw, bdone, bad;
        rst = 1'b1;
        a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b1;
        b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_ctl", {a_valid, a_busy, a_done, b_valid, b_busy, b_done}, 96'(0));
        check_eq("rst_addr", {a_pxl_row, a_pxl_col, a_win_row, a_win_col}, 96'(0));
        check_eq("rst_data", a_win_data, 96'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1x1 image, read latency 3
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        first = -1; bw = 0; bdone = 0;
        for (nb = 1; nb <= 40; nb++) begin
            @(posedge clk); #1;
            if (b_valid) begin
                if (bw == 0) first = nb;
                bw++;
                check_eq("b_data", b_win_data, pack9(8'h00, 8'h00, 8'h00, 8'h00, 8'hA5,
                         8'h00, 8'h00, 8'h00, 8'h00));
                check_eq("b_pos", {b_win_row, b_win_col}, 96'(0));
            end
            if (b_done) bdone++;
        end
        check_eq("b_first_valid", first, 12);
        check_eq("b_win_count", bw, 1);
        check_eq("b_done_count", bdone, 1);

        // Full frame with ready held high, then a frame stalled at window (1,3)
        run_frame(-1);
        repeat (3) @(posedge clk);
        #1;
        run_frame(8);
        repeat (3) @(posedge clk);
        #1;

        // Abort during FETCH of window (1,1), with a simultaneous start
        a_ready = 1'b1;
        pulse_a_start();
        repeat (68) @(posedge clk);
        #1;
        check_eq("abort_pxl", {a_pxl_row, a_pxl_col}, {9'd0, 9'd2});
        check_eq("abort_ctr", {a_win_row, a_win_col}, {9'd1, 9'd1});
        a_abort = 1'b1;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        a_start = 1'b0;
        check_eq("abort_idle", {a_busy, a_valid, a_done}, 96'(0));
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (a_busy || a_done || a_valid) bad++;
        end
        check_eq("abort_quiet", bad, 0);
        run_frame(-1);
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset while window (1,1) is presented
        pulse_a_start();
        repeat (76) @(posedge clk);
        #1;
        check_eq("pre_rst_valid", {a_valid, a_win_row, a_win_col}, {1'b1, 9'd1, 9'd1});
        check_eq("pre_rst_data", a_win_data, model_win(1, 1));
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_ctl", {a_valid, a_busy, a_done}, 96'(0));
        check_eq("arst_addr", {a_pxl_row, a_pxl_col, a_win_row, a_win_col}, 96'(0));
        check_eq("arst_data", a_win_data, 96'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(-1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
